wb_ram_bank_bridge: RTL and testbench

Single-clock Wishbone classic slave that bridges one bus master onto NUM_BANKS synchronous single-port RAM banks (IRAM, DRAM, scratch, ...). It is the parametrised successor of the two-bank IRAM/DRAM interface. It adds a configurable bank count, byte-lane write masks via wb_sel_i, a configurable RAM read latency, cycle-abort handling, and a wb_err_o response for unmapped addresses. It sits between the core's data/instruction Wishbone interconnect and the RAM macros.

---
 rtl/wb_ram_pkg.sv | 18 +
 rtl/wb_ram_bank_bridge.sv | 162 ++++++++++++++++
 tb/tb_wb_ram_bank_bridge.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_ram_pkg.sv
// Shared definitions for the Wishbone-to-RAM-bank bridge: FSM encoding
// and the default bank map.
package wb_ram_pkg;

  localparam int BANK_SEL_LSB   = 20;
  localparam int BANK_SEL_WIDTH = 3;

  localparam logic [BANK_SEL_WIDTH-1:0] BANK_DRAM = 3'h0;
  localparam logic [BANK_SEL_WIDTH-1:0] BANK_IRAM = 3'h1;

  typedef logic [1:0] wb_state_t;

  localparam wb_state_t ST_IDLE   = 2'd0;
  localparam wb_state_t ST_ACCESS = 2'd1;
  localparam wb_state_t ST_WAIT   = 2'd2;
  localparam wb_state_t ST_RESP   = 2'd3;

endpackage

// File: rtl/wb_ram_bank_bridge.sv
// Wishbone classic slave fanning one master out to NUM_BANKS synchronous
// single-port RAM banks, with byte lanes, read latency and error response.
module wb_ram_bank_bridge
  import wb_ram_pkg::*;
#(
  parameter int NUM_BANKS      = 2,
  parameter int WB_ADDR_WIDTH  = 32,
  parameter int RAM_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_LSB        = BANK_SEL_LSB,
  parameter int SEL_WIDTH      = BANK_SEL_WIDTH,
  parameter int RD_LATENCY     = 1
) (
  input  logic                               wb_clk_i,
  input  logic                               rst_ni,
  input  logic                               wb_cyc_i,
  input  logic                               wb_stb_i,
  input  logic                               wb_we_i,
  input  logic [WB_ADDR_WIDTH-1:0]           wb_addr_i,
  input  logic [DATA_WIDTH/8-1:0]            wb_sel_i,
  input  logic [DATA_WIDTH-1:0]              wb_wdata_i,
  output logic [DATA_WIDTH-1:0]              wb_rdata_o,
  output logic                               wb_ack_o,
  output logic                               wb_err_o,
  output logic [RAM_ADDR_WIDTH-1:0]          ram_addr_o,
  output logic [DATA_WIDTH-1:0]              ram_wdata_o,
  output logic [NUM_BANKS-1:0]               ram_en_o,
  output logic [NUM_BANKS*DATA_WIDTH/8-1:0]  ram_we_o,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]    ram_rdata_i
);

  localparam int BE_W = DATA_WIDTH / 8;

  if (NUM_BANKS < 1 || NUM_BANKS > (1 << SEL_WIDTH)) begin : g_bad_banks
    $error("wb_ram_bank_bridge: NUM_BANKS must be 1..2**SEL_WIDTH");
  end
  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("wb_ram_bank_bridge: RD_LATENCY must be 1..4");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_width
    $error("wb_ram_bank_bridge: DATA_WIDTH must be a multiple of 8");
  end

  wb_state_t                  state_q;
  logic [1:0]                 cnt_q;
  logic                       we_q;
  logic                       abort_q;
  logic [NUM_BANKS-1:0]       bank_sel_q;

  logic [SEL_WIDTH-1:0]       idx;
  logic [NUM_BANKS-1:0]       en_dec;
  logic [NUM_BANKS*BE_W-1:0]  we_dec;
  logic                       mapped;
  logic [DATA_WIDTH-1:0]      rd_mux;
  logic                       unused_addr;

  assign idx         = wb_addr_i[SEL_LSB +: SEL_WIDTH];
  assign mapped      = |en_dec;
  assign unused_addr = ^wb_addr_i;

  // One-hot bank decode; an index beyond NUM_BANKS matches no bank and is unmapped.
  always_comb begin
    en_dec = '0;
    we_dec = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (idx == SEL_WIDTH'(k)) begin
        en_dec[k] = 1'b1;
        if (wb_we_i) begin
          we_dec[k*BE_W +: BE_W] = wb_sel_i;
        end
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (bank_sel_q[k]) begin
        rd_mux = rd_mux | ram_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A dropped cycle never cancels the RAM access; it only suppresses the
  // ack and sends the FSM straight back to IDLE at the completion point.
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      abort_q     <= 1'b0;
      bank_sel_q  <= '0;
      wb_rdata_o  <= '0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_wdata_o <= '0;
      ram_en_o    <= '0;
      ram_we_o    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            abort_q <= 1'b0;
            if (mapped) begin
              ram_addr_o  <= wb_addr_i[RAM_ADDR_WIDTH+1:2];
              ram_wdata_o <= wb_wdata_i;
              ram_en_o    <= en_dec;
              ram_we_o    <= we_dec;
              bank_sel_q  <= en_dec;
              we_q        <= wb_we_i;
              state_q     <= ST_ACCESS;
            end else begin
              wb_err_o <= 1'b1;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_ACCESS: begin
          ram_en_o <= '0;
          ram_we_o <= '0;
          cnt_q    <= 2'(RD_LATENCY - 1);
          if (we_q || RD_LATENCY == 1) begin
            if (wb_cyc_i) begin
              wb_ack_o <= 1'b1;
              if (!we_q) begin
                wb_rdata_o <= rd_mux;
              end
              state_q <= ST_RESP;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            abort_q <= ~wb_cyc_i;
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - 2'd1;
          if (cnt_q == 2'd1) begin
            if (wb_cyc_i && !abort_q) begin
              wb_ack_o   <= 1'b1;
              wb_rdata_o <= rd_mux;
              state_q    <= ST_RESP;
            end else begin
              state_q <= ST_IDLE;
            end
          end else if (!wb_cyc_i) begin
            abort_q <= 1'b1;
          end
        end
        ST_RESP: begin
          wb_ack_o <= 1'b0;
          wb_err_o <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_bank_bridge.sv
// Directed bench: two bridges (read latency 1 and 3) share one bus master and
// are checked every cycle against a transaction-level timeline model.
`timescale 1ns/100ps
module tb_wb_ram_bank_bridge;
  import wb_ram_pkg::*;

  localparam int NB    = 2;
  localparam int RAW   = 18;
  localparam int DEPTH = 512;

  logic        wb_clk_i = 1'b0;
  logic        rst_ni;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_addr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_wdata_i;

  logic [1:0][31:0]    rdata_o;
  logic [1:0]          ack_o, err_o;
  logic [1:0][RAW-1:0] raddr_o;
  logic [1:0][31:0]    rwdata_o;
  logic [1:0][1:0]     en_o;
  logic [1:0][7:0]     we_o;
  logic [1:0][63:0]    rram_i;

  logic [31:0] mem [2][2][64];
  logic        mem_ready = 1'b0;
  logic [31:0] ref_mem [2][64];

  logic [1:0]     exp_en   [2][DEPTH];
  logic [7:0]     exp_we   [2][DEPTH];
  bit             exp_ack  [2][DEPTH];
  bit             exp_err  [2][DEPTH];
  logic [RAW-1:0] exp_addr [2][DEPTH];
  logic [31:0]    exp_wd   [2][DEPTH];
  bit             rd_set   [2][DEPTH];
  logic [31:0]    rd_val   [2][DEPTH];
  logic [31:0]    exp_rdata [2];

  int cyc_n = 0;
  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b1;
  int last_stb = 0;
  int ack_cyc [2];
  int err_cyc [2];
  logic [1:0]     last_en   [2];
  logic [7:0]     last_we   [2];
  logic [RAW-1:0] last_addr [2];

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc_n <= cyc_n + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wb_ram_bank_bridge #(
      .NUM_BANKS(NB), .WB_ADDR_WIDTH(32), .RAM_ADDR_WIDTH(RAW), .DATA_WIDTH(32),
      .SEL_LSB(BANK_SEL_LSB), .SEL_WIDTH(BANK_SEL_WIDTH), .RD_LATENCY(g == 0 ? 1 : 3)
    ) u_dut (
      .wb_clk_i(wb_clk_i), .rst_ni(rst_ni),
      .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_addr_i(wb_addr_i), .wb_sel_i(wb_sel_i), .wb_wdata_i(wb_wdata_i),
      .wb_rdata_o(rdata_o[g]), .wb_ack_o(ack_o[g]), .wb_err_o(err_o[g]),
      .ram_addr_o(raddr_o[g]), .ram_wdata_o(rwdata_o[g]),
      .ram_en_o(en_o[g]), .ram_we_o(we_o[g]), .ram_rdata_i(rram_i[g])
    );
    assign rram_i[g] = {mem[g][1][raddr_o[g][5:0]], mem[g][0][raddr_o[g][5:0]]};
  end

  function automatic logic [31:0] init_word(int b, int i);
    return 32'hC0DE_0000 | 32'(b << 8) | 32'(i);
  endfunction

  // Environment RAM banks: byte-writable, read port follows the shared address.
  always @(posedge wb_clk_i) begin
    if (!mem_ready) begin
      for (int g = 0; g < 2; g++)
        for (int b = 0; b < 2; b++)
          for (int i = 0; i < 64; i++) mem[g][b][i] <= init_word(b, i);
      mem_ready <= 1'b1;
    end else begin
      for (int g = 0; g < 2; g++)
        for (int b = 0; b < 2; b++)
          for (int j = 0; j < 4; j++)
            if (en_o[g][b] && we_o[g][b*4+j])
              mem[g][b][raddr_o[g][5:0]][8*j +: 8] <= rwdata_o[g][8*j +: 8];
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge wb_clk_i) begin
    if (checking && cyc_n < DEPTH) begin
      for (int d = 0; d < 2; d++) begin
        if (rd_set[d][cyc_n]) exp_rdata[d] = rd_val[d][cyc_n];
        check_output($sformatf("d%0d_en@%0d", d, cyc_n), 64'(en_o[d]), 64'(exp_en[d][cyc_n]));
        check_output($sformatf("d%0d_we@%0d", d, cyc_n), 64'(we_o[d]), 64'(exp_we[d][cyc_n]));
        check_output($sformatf("d%0d_ack@%0d", d, cyc_n), 64'(ack_o[d]), 64'(exp_ack[d][cyc_n]));
        check_output($sformatf("d%0d_err@%0d", d, cyc_n), 64'(err_o[d]), 64'(exp_err[d][cyc_n]));
        check_output($sformatf("d%0d_rdata@%0d", d, cyc_n), 64'(rdata_o[d]), 64'(exp_rdata[d]));
        if (exp_en[d][cyc_n] != 2'b00) begin
          check_output($sformatf("d%0d_addr@%0d", d, cyc_n), 64'(raddr_o[d]), 64'(exp_addr[d][cyc_n]));
          if (exp_we[d][cyc_n] != 8'h00)
            check_output($sformatf("d%0d_wdata@%0d", d, cyc_n), 64'(rwdata_o[d]), 64'(exp_wd[d][cyc_n]));
        end
        if (en_o[d] != 2'b00) begin
          last_en[d]   = en_o[d];
          last_we[d]   = we_o[d];
          last_addr[d] = raddr_o[d];
        end
        if (ack_o[d]) ack_cyc[d] = cyc_n;
        if (err_o[d]) err_cyc[d] = cyc_n;
      end
    end
  end

  // One transaction: stb for one cycle, cyc held until cycle drop_off (0 = no early drop).
  task automatic apply_stimulus(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                                input logic [31:0] wdata, input int drop_off);
    int n, idx, word, eff;
    bit ab;
    n        = cyc_n;
    last_stb = n;
    idx      = int'(addr[BANK_SEL_LSB +: BANK_SEL_WIDTH]);
    word     = int'(addr[7:2]);
    for (int d = 0; d < 2; d++) begin
      eff = we ? 1 : (d == 0 ? 1 : 3);
      if (idx < NB) begin
        exp_en[d][n+1]   = 2'(1 << idx);
        exp_we[d][n+1]   = we ? 8'(32'(sel) << (4 * idx)) : 8'h00;
        exp_addr[d][n+1] = addr[RAW+1:2];
        exp_wd[d][n+1]   = wdata;
        ab = (drop_off >= 1) && (drop_off <= eff);
        if (!ab) begin
          exp_ack[d][n+1+eff] = 1'b1;
          if (!we) begin
            rd_set[d][n+1+eff] = 1'b1;
            rd_val[d][n+1+eff] = ref_mem[idx][word];
          end
        end
      end else begin
        exp_err[d][n+1] = 1'b1;
      end
    end
    if (idx < NB && we)
      for (int j = 0; j < 4; j++)
        if (sel[j]) ref_mem[idx][word][8*j +: 8] = wdata[8*j +: 8];
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_addr_i = addr; wb_sel_i = sel; wb_wdata_i = wdata;
    for (int k = 1; k <= 6; k++) begin
      @(posedge wb_clk_i); #2;
      if (k == 1) wb_stb_i = 1'b0;
      if (k == drop_off || k == 5) wb_cyc_i = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] a_iram;
    a_iram = {9'b0, BANK_IRAM, 20'h00040};
    for (int d = 0; d < 2; d++) begin
      exp_rdata[d] = '0; ack_cyc[d] = -100; err_cyc[d] = -100;
      last_en[d] = '0; last_we[d] = '0; last_addr[d] = '0;
      for (int c = 0; c < DEPTH; c++) begin
        exp_en[d][c] = '0; exp_we[d][c] = '0; exp_ack[d][c] = 0; exp_err[d][c] = 0;
        exp_addr[d][c] = '0; exp_wd[d][c] = '0; rd_set[d][c] = 0; rd_val[d][c] = '0;
      end
    end
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 64; i++) ref_mem[b][i] = init_word(b, i);

    rst_ni = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_addr_i = '0; wb_sel_i = '0; wb_wdata_i = '0;
    repeat (3) @(posedge wb_clk_i);
    #2 rst_ni = 1'b1;
    @(posedge wb_clk_i); #2;

    apply_stimulus(a_iram, 1'b1, 4'hF, 32'hDEAD_BEEF, 0);
    check_output("wr_en_bank1", 64'(last_en[0]), 64'h2);
    check_output("wr_we_bank1", 64'(last_we[0]), 64'hF0);
    check_output("wr_ram_addr", 64'(last_addr[0]), 64'h10);
    check_output("wr_ack_delay_l1", 64'(ack_cyc[0] - last_stb), 64'd2);
    check_output("wr_ack_delay_l3", 64'(ack_cyc[1] - last_stb), 64'd2);

    apply_stimulus(a_iram, 1'b0, 4'h0, 32'h0, 0);
    check_output("rd_data_l1", 64'(rdata_o[0]), 64'hDEAD_BEEF);
    check_output("rd_data_l3", 64'(rdata_o[1]), 64'hDEAD_BEEF);
    check_output("rd_ack_delay_l1", 64'(ack_cyc[0] - last_stb), 64'd2);
    check_output("rd_ack_delay_l3", 64'(ack_cyc[1] - last_stb), 64'd4);

    apply_stimulus(32'h0000_0044, 1'b1, 4'b0100, 32'h00AB_0000, 0);
    check_output("byte_we_bank0", 64'(last_we[0]), 64'h04);
    apply_stimulus(32'h0000_0044, 1'b0, 4'hF, 32'h0, 0);
    check_output("byte_merge", 64'(rdata_o[0]), 64'hC0AB_0011);

    apply_stimulus(32'h0070_0000, 1'b0, 4'hF, 32'h0, 0);
    check_output("err_delay", 64'(err_cyc[0] - last_stb), 64'd1);

    apply_stimulus(32'h0000_0048, 1'b0, 4'hF, 32'h0, 2);
    check_output("abort_rdata_held", 64'(rdata_o[1]), 64'hC0AB_0011);
    check_output("no_abort_l1", 64'(rdata_o[0]), 64'hC0DE_0012);
    apply_stimulus(a_iram, 1'b0, 4'hF, 32'h0, 0);
    check_output("after_abort_rd", 64'(rdata_o[1]), 64'hDEAD_BEEF);

    apply_stimulus(a_iram + 32'h4, 1'b1, 4'h0, 32'hFFFF_FFFF, 0);
    apply_stimulus(a_iram + 32'h4, 1'b0, 4'hF, 32'h0, 0);
    check_output("sel0_nowrite", 64'(rdata_o[0]), 64'hC0DE_0111);

    apply_stimulus(32'h0030_0000, 1'b1, 4'hF, 32'h5555_5555, 0);
    apply_stimulus(32'h0000_004C, 1'b1, 4'hF, 32'h1122_3344, 1);
    apply_stimulus(32'h0000_004C, 1'b0, 4'hF, 32'h0, 0);
    check_output("aborted_write_lands", 64'(rdata_o[1]), 64'h1122_3344);

    // Reset in the ACCESS cycle of a write: outputs drop at once, RAM never written.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_addr_i = 32'h0000_0048; wb_sel_i = 4'hF; wb_wdata_i = 32'h1234_5678;
    @(posedge wb_clk_i); #2;
    wb_stb_i = 1'b0;
    #1;
    check_output("rst_pre_en", 64'(en_o[0]), 64'h1);
    rst_ni = 1'b0;
    for (int d = 0; d < 2; d++) begin
      for (int c = cyc_n; c < DEPTH; c++) begin
        exp_en[d][c] = '0; exp_we[d][c] = '0; exp_ack[d][c] = 0; exp_err[d][c] = 0;
        rd_set[d][c] = 0;
      end
      rd_set[d][cyc_n] = 1'b1;
      rd_val[d][cyc_n] = '0;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("rst_en_d%0d", d), 64'(en_o[d]), 64'h0);
      check_output($sformatf("rst_we_d%0d", d), 64'(we_o[d]), 64'h0);
      check_output($sformatf("rst_ack_d%0d", d), 64'(ack_o[d]), 64'h0);
      check_output($sformatf("rst_rdata_d%0d", d), 64'(rdata_o[d]), 64'h0);
      check_output($sformatf("rst_addr_d%0d", d), 64'(raddr_o[d]), 64'h0);
    end
    wb_cyc_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #2 rst_ni = 1'b1;
    @(posedge wb_clk_i); #2;

    apply_stimulus(32'h0000_0048, 1'b0, 4'hF, 32'h0, 0);
    check_output("post_rst_rd_l1", 64'(rdata_o[0]), 64'hC0DE_0012);
    check_output("post_rst_rd_l3", 64'(rdata_o[1]), 64'hC0DE_0012);
    check_output("post_rst_delay_l3", 64'(ack_cyc[1] - last_stb), 64'd4);

    repeat (2) @(posedge wb_clk_i);
    checking = 1'b0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
